// File: rtl/store_buffer.sv
// store_buffer: MEM-stage store FIFO with youngest-match load forwarding and in-order drain.
// Build macro STORE_COALESCE_EN lets a store overwrite an already-buffered entry with the same address.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ex_address,
  input  logic [DATA_W-1:0] ex_write_data,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  output logic              stall,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              buffer_empty,
  output logic [ADDR_W-1:0] dm_address,
  output logic [DATA_W-1:0] dm_write_data,
  output logic              dm_mem_read,
  output logic              dm_mem_write,
  input  logic [DATA_W-1:0] dm_read_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD_ISSUE, S_LOAD_WAIT} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] ent_addr_q [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic [DATA_W-1:0] load_data_q, load_data_d;
  logic              load_valid_q, load_valid_d;

  logic              full, ld_hit, coalesce_hit, st_acc, ld_acc, ld_miss, drain, enq;
  logic [DATA_W-1:0] ld_hit_data;
  logic [PTR_W-1:0]  coal_idx;

  assign full = (count_q == CNT_W'(DEPTH));

  // Scan oldest to youngest so the last match (youngest store) wins.
  always_comb begin : forward_search
    logic [PTR_W-1:0] idx;
    idx         = '0;
    ld_hit      = 1'b0;
    ld_hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (ent_addr_q[idx] == ex_address)) begin
        ld_hit      = 1'b1;
        ld_hit_data = ent_data_q[idx];
      end
    end
  end

`ifdef STORE_COALESCE_EN
  // Slot 0 is skipped: whenever a store can be accepted the head is draining this cycle.
  always_comb begin : coalesce_search
    logic [PTR_W-1:0] idx;
    idx          = '0;
    coalesce_hit = 1'b0;
    coal_idx     = '0;
    for (int i = 1; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (ex_mem_write && (CNT_W'(i) < count_q) && (ent_addr_q[idx] == ex_address)) begin
        coalesce_hit = 1'b1;
        coal_idx     = idx;
      end
    end
  end
`else
  assign coalesce_hit = 1'b0;
  assign coal_idx     = '0;
`endif

  assign stall   = (state_q != S_IDLE) | (ex_mem_write & full & ~coalesce_hit);
  assign st_acc  = ex_mem_write & ~stall;
  assign ld_acc  = ex_mem_read & ~ex_mem_write & ~stall;
  assign ld_miss = ld_acc & ~ld_hit;
  assign enq     = st_acc & ~coalesce_hit;
  assign drain   = (state_q == S_IDLE) & (count_q != '0) & ~ld_miss;

  always_comb begin : next_state
    state_d       = state_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    ld_addr_d     = ld_addr_q;
    load_data_d   = load_data_q;
    load_valid_d  = 1'b0;
    dm_address    = '0;
    dm_write_data = '0;
    dm_mem_read   = 1'b0;
    dm_mem_write  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ld_acc && ld_hit) begin
          load_data_d  = ld_hit_data;
          load_valid_d = 1'b1;
        end
        if (ld_miss) begin
          ld_addr_d = ex_address;
          state_d   = S_LOAD_ISSUE;
        end
        if (drain) begin
          dm_mem_write  = 1'b1;
          dm_address    = ent_addr_q[head_q];
          dm_write_data = ent_data_q[head_q];
          head_d        = head_q + PTR_W'(1);
        end
        if (enq) tail_d = tail_q + PTR_W'(1);
        case ({enq, drain})
          2'b10:   count_d = count_q + CNT_W'(1);
          2'b01:   count_d = count_q - CNT_W'(1);
          default: count_d = count_q;
        endcase
      end
      S_LOAD_ISSUE: begin
        dm_mem_read = 1'b1;
        dm_address  = ld_addr_q;
        state_d     = S_LOAD_WAIT;
      end
      S_LOAD_WAIT: begin
        dm_mem_read  = 1'b1;
        dm_address   = ld_addr_q;
        load_data_d  = dm_read_data;
        load_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      ld_addr_q    <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr_q[i] <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      ld_addr_q    <= ld_addr_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      if (enq) begin
        ent_addr_q[tail_q] <= ex_address;
        ent_data_q[tail_q] <= ex_write_data;
      end
      if (st_acc && coalesce_hit) ent_data_q[coal_idx] <= ex_write_data;
    end
  end

  assign load_data    = load_data_q;
  assign load_valid   = load_valid_q;
  assign buffer_empty = (count_q == '0) && (state_q == S_IDLE);

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic against a queue-based reference model.
// The model follows STORE_COALESCE_EN the same way the design build does.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic        clock, reset;
  logic [31:0] ex_address, ex_write_data;
  logic        ex_mem_read, ex_mem_write;
  logic        stall, load_valid, buffer_empty, dm_mem_read, dm_mem_write;
  logic [31:0] load_data, dm_address, dm_write_data, dm_read_data;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .ex_address(ex_address), .ex_write_data(ex_write_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .stall(stall), .load_data(load_data), .load_valid(load_valid), .buffer_empty(buffer_empty),
    .dm_address(dm_address), .dm_write_data(dm_write_data),
    .dm_mem_read(dm_mem_read), .dm_mem_write(dm_mem_write), .dm_read_data(dm_read_data)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return 32'd6 + a * 32'd5;
  endfunction

  // data_memory stand-in: synchronous read, write on the rising edge
  logic [31:0] mem [64];
  bit          mem_wr [64];
  logic [31:0] rd_q;
  logic [31:0] act_drain_a[$], act_drain_d[$];
  int          wr_cnt, rd_cnt;

  always @(posedge clock) begin
    if (dm_mem_write) begin
      mem[dm_address[5:0]]    <= dm_write_data;
      mem_wr[dm_address[5:0]] <= 1'b1;
      act_drain_a.push_back(dm_address);
      act_drain_d.push_back(dm_write_data);
      wr_cnt <= wr_cnt + 1;
    end
    if (dm_mem_read) begin
      rd_q   <= mem_wr[dm_address[5:0]] ? mem[dm_address[5:0]] : mem_init(dm_address);
      rd_cnt <= rd_cnt + 1;
    end
  end
  assign dm_read_data = rd_q;

  int n_checks = 0, n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: program-ordered store queue, memory image, and miss phase (0 none, 1 issue, 2 wait).
  typedef struct packed {logic [31:0] a; logic [31:0] d;} ent_t;
  ent_t        sbq[$];
  logic [31:0] ref_mem[int];
  int          phase;
  logic [31:0] m_addr, m_ld;
  bit          m_lv;

  logic [31:0] obs_stall, obs_we, obs_rd, obs_addr, obs_wd, obs_lv, obs_ld, obs_empty;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : mem_init(a);
  endfunction

  task automatic model_reset();
    sbq.delete();
    phase = 0;
    m_lv  = 1'b0;
    m_ld  = '0;
  endtask

  task automatic cycle(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                       output bit stalled);
    bit e_stall, coal, ld, hit, miss, drn, nlv;
    int cidx;
    logic [31:0] hdata, e_addr, e_wd;
    ex_mem_write  = w;
    ex_mem_read   = r;
    ex_address    = a;
    ex_write_data = d;
    @(negedge clock);
    coal = 1'b0;
    cidx = 0;
`ifdef STORE_COALESCE_EN
    // the head drains in any cycle a store is taken, so it is not a merge target
    if (w) for (int k = sbq.size() - 1; k >= 1; k--)
      if (!coal && sbq[k].a == a) begin coal = 1'b1; cidx = k; end
`endif
    e_stall = (phase != 0) || (w && sbq.size() == DEPTH && !coal);
    ld  = r && !w && !e_stall;
    hit = 1'b0;
    hdata = '0;
    for (int k = sbq.size() - 1; k >= 0; k--)
      if (!hit && sbq[k].a == a) begin hit = 1'b1; hdata = sbq[k].d; end
    miss = ld && !hit;
    drn  = (phase == 0) && (sbq.size() > 0) && !miss;
    e_addr = (phase != 0) ? m_addr : (drn ? sbq[0].a : 32'd0);
    e_wd   = drn ? sbq[0].d : 32'd0;
    obs_stall = 32'(stall);   obs_we = 32'(dm_mem_write); obs_rd = 32'(dm_mem_read);
    obs_addr  = dm_address;   obs_wd = dm_write_data;     obs_lv = 32'(load_valid);
    obs_ld    = load_data;    obs_empty = 32'(buffer_empty);
    chk("stall", obs_stall, 32'(e_stall));
    chk("dm_mem_write", obs_we, 32'(drn));
    chk("dm_mem_read", obs_rd, 32'(phase != 0));
    chk("dm_address", obs_addr, e_addr);
    chk("dm_write_data", obs_wd, e_wd);
    chk("load_valid", obs_lv, 32'(m_lv));
    chk("load_data", obs_ld, m_ld);
    chk("buffer_empty", obs_empty, 32'(sbq.size() == 0 && phase == 0));
    nlv = 1'b0;
    if (phase == 2) begin
      m_ld = ref_read(m_addr);
      nlv = 1'b1;
      phase = 0;
    end else if (phase == 1) begin
      phase = 2;
    end else begin
      if (w && !e_stall) begin
        if (coal) sbq[cidx].d = d;
        else sbq.push_back('{a: a, d: d});
      end
      if (ld && hit) begin m_ld = hdata; nlv = 1'b1; end
      if (miss) begin phase = 1; m_addr = a; end
      if (drn) begin
        ref_mem[int'(sbq[0].a)] = sbq[0].d;
        void'(sbq.pop_front());
      end
    end
    m_lv = nlv;
    stalled = e_stall;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ex_mem_write = 1'b0; ex_mem_read = 1'b0; ex_address = '0; ex_write_data = '0;
    #1;
    model_reset();
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_empty", 32'(buffer_empty), 32'd1);
    chk("rst_load_valid", 32'(load_valid), 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_dm", {dm_address[29:0], dm_mem_read, dm_mem_write}, 32'd0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bit st;
    bit w, r;
    logic [31:0] a, d;
    int rc0, wc0;
    wr_cnt = 0;
    rd_cnt = 0;
    do_reset();

    // store drains the next cycle, buffer empty one cycle later
    cycle(1, 0, 18, 42, st);
    cycle(0, 0, 0, 0, st);
    chk("t1_we", obs_we, 1);
    chk("t1_addr", obs_addr, 18);
    chk("t1_wd", obs_wd, 42);
    cycle(0, 0, 0, 0, st);
    chk("t1_empty", obs_empty, 1);

    // forwarding from the draining head, no memory read
    rc0 = rd_cnt;
    cycle(1, 0, 19, 7, st);
    cycle(0, 1, 19, 0, st);
    cycle(0, 0, 0, 0, st);
    chk("t2_lv", obs_lv, 1);
    chk("t2_ld", obs_ld, 7);
    cycle(0, 0, 0, 0, st);
    chk("t2_no_rd", 32'(rd_cnt - rc0), 0);

    // load miss on empty buffer: latency 3
    cycle(0, 1, 0, 0, st);
    chk("t3_acc", obs_stall, 0);
    cycle(0, 0, 0, 0, st);
    chk("t3_stall1", obs_stall, 1);
    chk("t3_rd1", obs_rd, 1);
    cycle(0, 0, 0, 0, st);
    chk("t3_stall2", obs_stall, 1);
    chk("t3_rd2", obs_rd, 1);
    cycle(0, 0, 0, 0, st);
    chk("t3_lv", obs_lv, 1);
    chk("t3_ld", obs_ld, 6);

    // back-to-back stores drain in program order
    act_drain_a.delete();
    act_drain_d.delete();
    for (int i = 0; i < 5; i++) begin
      st = 1'b1;
      for (int g = 0; g < 20 && st; g++) cycle(1, 0, 32'(20 + i), 32'(100 + i), st);
    end
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, st);
    chk("t4_drains", 32'(act_drain_a.size()), 5);
    for (int i = 0; i < 5 && i < act_drain_a.size(); i++)
      chk("t4_order", act_drain_a[i], 32'(20 + i));

    // repeated store to one address, then load sees the younger value
    cycle(1, 0, 25, 1, st);
    cycle(1, 0, 25, 9, st);
    cycle(0, 1, 25, 0, st);
    cycle(0, 0, 0, 0, st);
    chk("t5_lv", obs_lv, 1);
    chk("t5_ld", obs_ld, 9);
    cycle(0, 0, 0, 0, st);
    chk("t5_last_drain", act_drain_d[$], 9);

    // random traffic; stalled requests are held by upstream
    st = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!st) begin
        w = ($urandom_range(0, 9) < 4);
        r = ($urandom_range(0, 9) < 4);
        a = 32'($urandom_range(0, 15));
        d = $urandom;
      end
      cycle(w, r, a, d, st);
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, st);

    // reset during LOAD_WAIT with a buffered store
    cycle(1, 0, 30, 5, st);
    cycle(0, 1, 40, 0, st);
    cycle(0, 0, 0, 0, st);
    wc0 = wr_cnt;
    reset = 1'b1;
    #1;
    chk("t6_stall", 32'(stall), 0);
    chk("t6_lv", 32'(load_valid), 0);
    chk("t6_empty", 32'(buffer_empty), 1);
    chk("t6_dm_rd", 32'(dm_mem_read), 0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, st);
    chk("t6_no_write", 32'(wr_cnt - wc0), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
